serial_chan_arbiter: RTL and testbench



---
 rtl/serial_mux_pkg.sv | 22 ++
 rtl/serial_rx_picker.sv | 38 +++
 rtl/serial_chan_arbiter.sv | 161 ++++++++++++++++
 tb/tb_serial_chan_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mux_pkg.sv
// Shared types and constants for the multi-serial bridge arbiter.
package serial_mux_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_POP,
      ST_OUT,
      ST_CLR
   } state_t;

   localparam int unsigned ERR_W     = 4;
   localparam int unsigned ERR_RX_WR = 0;
   localparam int unsigned ERR_RX_RD = 1;
   localparam int unsigned ERR_TX_WR = 2;
   localparam int unsigned ERR_TX_RD = 3;

   // 32-bit wide so they can be truncated to any priority width.
   localparam logic [31:0] PRIO_EMPTY = '0;
   localparam logic [31:0] PRIO_FULL  = '1;

endpackage

// File: rtl/serial_rx_picker.sv
// Picks the RX channel with the highest priority; ties resolve to the
// first index at or after rr_ptr, wrapping.
module serial_rx_picker
   import serial_mux_pkg::*;
#(
   parameter int unsigned N_CHAN = 8,
   parameter int unsigned PRIO_W = 3,
   parameter int unsigned CH_W   = $clog2(N_CHAN)
) (
   input  logic [N_CHAN*PRIO_W-1:0] chan_prio_rx,
   input  logic [CH_W-1:0]          rr_ptr,
   output logic                     pick_valid,
   output logic [CH_W-1:0]          pick_chan
);

   logic [PRIO_W-1:0] best;
   logic [PRIO_W-1:0] prio;
   int                idx;

   // Walk in rotated order; strict '>' keeps the earliest tied channel.
   always_comb begin
      best      = PRIO_W'(PRIO_EMPTY);
      prio      = '0;
      idx       = 0;
      pick_chan = '0;
      for (int k = 0; k < int'(N_CHAN); k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= int'(N_CHAN)) idx = idx - int'(N_CHAN);
         prio = chan_prio_rx[idx*PRIO_W +: PRIO_W];
         if (prio > best) begin
            best      = prio;
            pick_chan = CH_W'(idx);
         end
      end
      pick_valid = (best != PRIO_W'(PRIO_EMPTY));
   end

endmodule

// File: rtl/serial_chan_arbiter.sv
// Central arbiter: drains RX FIFOs to the host, commits host bytes to TX
// FIFOs and issues per-channel error clears, one channel per transaction.
module serial_chan_arbiter
   import serial_mux_pkg::*;
#(
   parameter int unsigned N_CHAN = 8,
   parameter int unsigned D_W    = 8,
   parameter int unsigned PRIO_W = 3,
   parameter int unsigned CH_W   = $clog2(N_CHAN)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   output logic [N_CHAN-1:0]         chan_active,
   output logic                      commit_write,
   output logic                      commit_read,
   output logic                      clear_flags,
   output logic [D_W-1:0]            chan_data_in,
   input  logic [N_CHAN*D_W-1:0]     chan_data_out,
   input  logic [N_CHAN*PRIO_W-1:0]  chan_prio_rx,
   input  logic [N_CHAN*PRIO_W-1:0]  chan_prio_tx,
   input  logic [N_CHAN*ERR_W-1:0]   chan_errors,
   output logic [N_CHAN-1:0]         err_summary,
   output logic [D_W-1:0]            host_rx_data,
   output logic [CH_W-1:0]           host_rx_chan,
   output logic                      host_rx_valid,
   input  logic                      host_rx_ready,
   input  logic [D_W-1:0]            host_tx_data,
   input  logic [CH_W-1:0]           host_tx_chan,
   input  logic                      host_tx_valid,
   output logic                      host_tx_ready,
   input  logic [CH_W-1:0]           host_clr_chan,
   input  logic                      host_clr_valid
);

   localparam logic [PRIO_W-1:0] TX_FULL = PRIO_W'(PRIO_FULL);

   state_t            state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   sel_chan;
   logic              toggle;

   logic              pick_valid;
   logic [CH_W-1:0]   pick_chan;
   logic [N_CHAN-1:0] tx_onehot, clr_onehot, pick_onehot, err_or;
   logic [PRIO_W-1:0] tx_prio;
   logic [D_W-1:0]    pop_data;
   logic [ERR_W-1:0]  err_bits;
   logic              wr_cand, rd_cand, clr_cand, idle_go;
   logic              clr_win, wr_win, rd_win;

   serial_rx_picker #(
      .N_CHAN (N_CHAN),
      .PRIO_W (PRIO_W),
      .CH_W   (CH_W)
   ) u_picker (
      .chan_prio_rx (chan_prio_rx),
      .rr_ptr       (rr_ptr),
      .pick_valid   (pick_valid),
      .pick_chan    (pick_chan)
   );

   // Channel decodes; an out-of-range index decodes to no channel.
   always_comb begin
      tx_onehot   = '0;
      clr_onehot  = '0;
      pick_onehot = '0;
      err_or      = '0;
      err_bits    = '0;
      tx_prio     = '0;
      pop_data    = '0;
      for (int i = 0; i < int'(N_CHAN); i++) begin
         if (host_tx_chan == CH_W'(i)) begin
            tx_onehot[i] = 1'b1;
            tx_prio      = chan_prio_tx[i*PRIO_W +: PRIO_W];
         end
         if (host_clr_chan == CH_W'(i)) clr_onehot[i] = 1'b1;
         if (pick_chan == CH_W'(i))     pick_onehot[i] = 1'b1;
         if (sel_chan == CH_W'(i))      pop_data = chan_data_out[i*D_W +: D_W];
         err_bits  = chan_errors[i*ERR_W +: ERR_W];
         err_or[i] = err_bits[ERR_RX_WR] | err_bits[ERR_RX_RD] |
                     err_bits[ERR_TX_WR] | err_bits[ERR_TX_RD];
      end
   end

   assign wr_cand  = host_tx_valid && (tx_prio != TX_FULL);
   assign rd_cand  = pick_valid;
   assign clr_cand = host_clr_valid && (|clr_onehot);
   assign idle_go  = (state == ST_IDLE) && enable;

   // Clear always wins; otherwise the toggle alternates write and read.
   assign clr_win = idle_go && clr_cand;
   assign wr_win  = idle_go && !clr_cand && wr_cand && (!rd_cand || !toggle);
   assign rd_win  = idle_go && !clr_cand && rd_cand && (!wr_cand || toggle);

   assign host_tx_ready = wr_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         rr_ptr        <= '0;
         sel_chan      <= '0;
         toggle        <= 1'b0;
         chan_active   <= '0;
         commit_write  <= 1'b0;
         commit_read   <= 1'b0;
         clear_flags   <= 1'b0;
         chan_data_in  <= '0;
         err_summary   <= '0;
         host_rx_data  <= '0;
         host_rx_chan  <= '0;
         host_rx_valid <= 1'b0;
      end else begin
         err_summary <= err_or;
         if ((wr_win || rd_win) && wr_cand && rd_cand) toggle <= ~toggle;
         case (state)
            ST_IDLE: begin
               if (clr_win) begin
                  state       <= ST_CLR;
                  chan_active <= clr_onehot;
                  clear_flags <= 1'b1;
               end else if (wr_win) begin
                  state        <= ST_WR;
                  chan_active  <= tx_onehot;
                  commit_write <= |tx_onehot;
                  chan_data_in <= host_tx_data;
               end else if (rd_win) begin
                  state       <= ST_POP;
                  sel_chan    <= pick_chan;
                  chan_active <= pick_onehot;
                  commit_read <= 1'b1;
               end
            end
            ST_WR, ST_CLR: begin
               state        <= ST_IDLE;
               chan_active  <= '0;
               commit_write <= 1'b0;
               clear_flags  <= 1'b0;
            end
            // FIFO head is fall-through, so the byte is valid during the pop.
            ST_POP: begin
               state         <= ST_OUT;
               chan_active   <= '0;
               commit_read   <= 1'b0;
               host_rx_data  <= pop_data;
               host_rx_chan  <= sel_chan;
               host_rx_valid <= 1'b1;
               rr_ptr        <= (sel_chan == CH_W'(N_CHAN - 1)) ? '0 : sel_chan + CH_W'(1);
            end
            ST_OUT: begin
               if (host_rx_ready) begin
                  state         <= ST_IDLE;
                  host_rx_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_chan_arbiter.sv
// Directed testbench for serial_chan_arbiter with hand-computed expectations.
module tb_serial_chan_arbiter;

   logic        clk, rst, enable;
   logic [7:0]  chan_active;
   logic        commit_write, commit_read, clear_flags;
   logic [7:0]  chan_data_in;
   logic [63:0] chan_data_out;
   logic [23:0] chan_prio_rx, chan_prio_tx;
   logic [31:0] chan_errors;
   logic [7:0]  err_summary;
   logic [7:0]  host_rx_data;
   logic [2:0]  host_rx_chan;
   logic        host_rx_valid, host_rx_ready;
   logic [7:0]  host_tx_data;
   logic [2:0]  host_tx_chan;
   logic        host_tx_valid, host_tx_ready;
   logic [2:0]  host_clr_chan;
   logic        host_clr_valid;

   int n_vec = 0;
   int n_err = 0;

   serial_chan_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .chan_active    (chan_active),
      .commit_write   (commit_write),
      .commit_read    (commit_read),
      .clear_flags    (clear_flags),
      .chan_data_in   (chan_data_in),
      .chan_data_out  (chan_data_out),
      .chan_prio_rx   (chan_prio_rx),
      .chan_prio_tx   (chan_prio_tx),
      .chan_errors    (chan_errors),
      .err_summary    (err_summary),
      .host_rx_data   (host_rx_data),
      .host_rx_chan   (host_rx_chan),
      .host_rx_valid  (host_rx_valid),
      .host_rx_ready  (host_rx_ready),
      .host_tx_data   (host_tx_data),
      .host_tx_chan   (host_tx_chan),
      .host_tx_valid  (host_tx_valid),
      .host_tx_ready  (host_tx_ready),
      .host_clr_chan  (host_clr_chan),
      .host_clr_valid (host_clr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int ch, input int p);
      chan_prio_rx[ch*3 +: 3] = 3'(p);
   endtask

   task automatic set_tx(input int ch, input int p);
      chan_prio_tx[ch*3 +: 3] = 3'(p);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_vec++; if (chan_active !== 8'h00) begin n_err++; $display("FAIL rst_active got %h exp 00", chan_active); end
      n_vec++; if ({commit_write, commit_read, clear_flags} !== 3'b000) begin n_err++; $display("FAIL rst_strobes got %b exp 000", {commit_write, commit_read, clear_flags}); end
      n_vec++; if (host_rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid got %b exp 0", host_rx_valid); end
      n_vec++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL rst_tx_ready got %b exp 0", host_tx_ready); end
      n_vec++; if (err_summary !== 8'h00) begin n_err++; $display("FAIL rst_err got %h exp 00", err_summary); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_err_summary();
      chan_errors = 32'h0;
      chan_errors[2*4 + 3] = 1'b1;
      chan_errors[5*4 + 0] = 1'b1;
      #1;
      n_vec++; if (err_summary !== 8'h00) begin n_err++; $display("FAIL err_lag got %h exp 00", err_summary); end
      tick();
      n_vec++; if (err_summary !== 8'h24) begin n_err++; $display("FAIL err_sum got %h exp 24", err_summary); end
      chan_errors = 32'h0;
      tick();
      n_vec++; if (err_summary !== 8'h00) begin n_err++; $display("FAIL err_clr got %h exp 00", err_summary); end
   endtask

   task automatic test_write();
      host_tx_valid = 1'b1; host_tx_chan = 3'd3; host_tx_data = 8'hA5;
      #1;
      n_vec++; if (host_tx_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready got %b exp 1", host_tx_ready); end
      tick();
      host_tx_valid = 1'b0;
      n_vec++; if (chan_active !== 8'h08) begin n_err++; $display("FAIL wr_active got %h exp 08", chan_active); end
      n_vec++; if ({commit_write, commit_read} !== 2'b10) begin n_err++; $display("FAIL wr_strobe got %b exp 10", {commit_write, commit_read}); end
      n_vec++; if (chan_data_in !== 8'hA5) begin n_err++; $display("FAIL wr_data got %h exp a5", chan_data_in); end
      tick();
      n_vec++; if ({chan_active, commit_write} !== 9'h0) begin n_err++; $display("FAIL wr_end got %h exp 000", {chan_active, commit_write}); end
   endtask

   task automatic test_priority_pick();
      set_rx(1, 2); set_rx(5, 6);
      tick();
      n_vec++; if (chan_active !== 8'h20) begin n_err++; $display("FAIL pick_active got %h exp 20", chan_active); end
      n_vec++; if (commit_read !== 1'b1) begin n_err++; $display("FAIL pick_pop got %b exp 1", commit_read); end
      set_rx(5, 0); set_rx(1, 0);
      tick();
      n_vec++; if (host_rx_valid !== 1'b1 || host_rx_chan !== 3'd5) begin n_err++; $display("FAIL pick_out got v=%b ch=%0d exp v=1 ch=5", host_rx_valid, host_rx_chan); end
      n_vec++; if (host_rx_data !== 8'h15) begin n_err++; $display("FAIL pick_data got %h exp 15", host_rx_data); end
      tick();
      tick();
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_oh [4];
      logic [2:0] exp_ch [4];
      int w;
      exp_oh[0] = 8'h04; exp_oh[1] = 8'h40; exp_oh[2] = 8'h04; exp_oh[3] = 8'h40;
      exp_ch[0] = 3'd2;  exp_ch[1] = 3'd6;  exp_ch[2] = 3'd2;  exp_ch[3] = 3'd6;
      rst = 1'b1; tick(); rst = 1'b0;
      set_rx(2, 4); set_rx(6, 4);
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (commit_read !== 1'b1 && w < 10) begin tick(); w++; end
         n_vec++; if (w >= 10) begin n_err++; $display("FAIL rr_timeout iter %0d got no pop exp pop", k); end
         n_vec++; if (chan_active !== exp_oh[k]) begin n_err++; $display("FAIL rr_active iter %0d got %h exp %h", k, chan_active, exp_oh[k]); end
         tick();
         n_vec++; if (host_rx_chan !== exp_ch[k] || host_rx_data !== 8'(8'h10 + exp_ch[k])) begin n_err++; $display("FAIL rr_out iter %0d got ch=%0d d=%h exp ch=%0d", k, host_rx_chan, host_rx_data, exp_ch[k]); end
      end
      set_rx(2, 0); set_rx(6, 0);
      tick();
      tick();
   endtask

   task automatic test_full_tx();
      set_tx(4, 7);
      host_tx_valid = 1'b1; host_tx_chan = 3'd4; host_tx_data = 8'h3C;
      set_rx(0, 1);
      #1;
      n_vec++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", host_tx_ready); end
      tick();
      n_vec++; if (chan_active !== 8'h01 || commit_read !== 1'b1) begin n_err++; $display("FAIL full_pop got %h/%b exp 01/1", chan_active, commit_read); end
      set_rx(0, 0);
      tick();
      n_vec++; if (host_rx_chan !== 3'd0 || host_rx_data !== 8'h10) begin n_err++; $display("FAIL full_out got ch=%0d d=%h exp ch=0 d=10", host_rx_chan, host_rx_data); end
      tick();
      n_vec++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL full_stall got %b exp 0", host_tx_ready); end
      set_tx(4, 6);
      #1;
      n_vec++; if (host_tx_ready !== 1'b1) begin n_err++; $display("FAIL full_release got %b exp 1", host_tx_ready); end
      tick();
      host_tx_valid = 1'b0;
      n_vec++; if (chan_active !== 8'h10 || commit_write !== 1'b1 || chan_data_in !== 8'h3C) begin n_err++; $display("FAIL full_wr got %h/%b/%h exp 10/1/3c", chan_active, commit_write, chan_data_in); end
      set_tx(4, 2);
      tick();
   endtask

   task automatic test_backpressure_reset();
      host_rx_ready = 1'b0;
      set_rx(3, 5);
      tick();
      n_vec++; if (chan_active !== 8'h08 || commit_read !== 1'b1) begin n_err++; $display("FAIL bp_pop got %h/%b exp 08/1", chan_active, commit_read); end
      set_rx(3, 0);
      set_rx(1, 3);
      tick();
      chan_data_out[3*8 +: 8] = 8'hEE;
      for (int c = 0; c < 10; c++) begin
         n_vec++; if (host_rx_valid !== 1'b1 || host_rx_data !== 8'h13 || commit_read !== 1'b0) begin n_err++; $display("FAIL bp_hold cyc %0d got v=%b d=%h pop=%b exp v=1 d=13 pop=0", c, host_rx_valid, host_rx_data, commit_read); end
         tick();
      end
      rst = 1'b1;
      #1;
      n_vec++; if (host_rx_valid !== 1'b0 || host_rx_data !== 8'h00 || host_rx_chan !== 3'd0) begin n_err++; $display("FAIL bp_rst_out got v=%b d=%h ch=%0d exp 0", host_rx_valid, host_rx_data, host_rx_chan); end
      n_vec++; if ({chan_active, commit_write, commit_read, clear_flags} !== 11'h0) begin n_err++; $display("FAIL bp_rst_strobe got %h exp 000", {chan_active, commit_write, commit_read, clear_flags}); end
      set_rx(1, 0);
      chan_data_out[3*8 +: 8] = 8'h13;
      host_rx_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_clear();
      host_tx_valid = 1'b1; host_tx_chan = 3'd1; host_tx_data = 8'h5A;
      host_clr_valid = 1'b1; host_clr_chan = 3'd7;
      #1;
      n_vec++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL clr_block got %b exp 0", host_tx_ready); end
      tick();
      host_clr_valid = 1'b0;
      n_vec++; if (clear_flags !== 1'b1 || chan_active !== 8'h80 || commit_write !== 1'b0) begin n_err++; $display("FAIL clr_strobe got %b/%h/%b exp 1/80/0", clear_flags, chan_active, commit_write); end
      tick();
      n_vec++; if (clear_flags !== 1'b0 || host_tx_ready !== 1'b1) begin n_err++; $display("FAIL clr_after got clr=%b rdy=%b exp 0/1", clear_flags, host_tx_ready); end
      tick();
      host_tx_valid = 1'b0;
      n_vec++; if (chan_active !== 8'h02 || commit_write !== 1'b1 || chan_data_in !== 8'h5A) begin n_err++; $display("FAIL clr_wr got %h/%b/%h exp 02/1/5a", chan_active, commit_write, chan_data_in); end
      tick();
   endtask

   task automatic test_enable();
      enable = 1'b0;
      set_rx(2, 1);
      host_tx_valid = 1'b1; host_tx_chan = 3'd0; host_tx_data = 8'h11;
      #1;
      n_vec++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL en_ready got %b exp 0", host_tx_ready); end
      tick(); tick(); tick();
      n_vec++; if ({chan_active, commit_write, commit_read} !== 10'h0) begin n_err++; $display("FAIL en_idle got %h exp 000", {chan_active, commit_write, commit_read}); end
      enable = 1'b1;
      #1;
      n_vec++; if (host_tx_ready !== 1'b1) begin n_err++; $display("FAIL en_wrfirst got %b exp 1", host_tx_ready); end
      tick();
      host_tx_valid = 1'b0;
      set_rx(2, 0);
      n_vec++; if (chan_active !== 8'h01 || commit_write !== 1'b1) begin n_err++; $display("FAIL en_wr got %h/%b exp 01/1", chan_active, commit_write); end
      tick();
   endtask

   task automatic test_alternate();
      host_tx_valid = 1'b1; host_tx_chan = 3'd0; host_tx_data = 8'h77;
      set_rx(4, 2);
      #1;
      n_vec++; if (host_tx_ready !== 1'b0) begin n_err++; $display("FAIL alt_rdfirst got %b exp 0", host_tx_ready); end
      tick();
      n_vec++; if (chan_active !== 8'h10 || commit_read !== 1'b1) begin n_err++; $display("FAIL alt_pop got %h/%b exp 10/1", chan_active, commit_read); end
      tick();
      tick();
      n_vec++; if (host_tx_ready !== 1'b1) begin n_err++; $display("FAIL alt_wrnext got %b exp 1", host_tx_ready); end
      tick();
      host_tx_valid = 1'b0;
      set_rx(4, 0);
      n_vec++; if (chan_active !== 8'h01 || commit_write !== 1'b1 || chan_data_in !== 8'h77) begin n_err++; $display("FAIL alt_wr got %h/%b/%h exp 01/1/77", chan_active, commit_write, chan_data_in); end
      tick();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1;
      chan_prio_rx = '0; chan_prio_tx = '0; chan_errors = '0;
      for (int i = 0; i < 8; i++) chan_data_out[i*8 +: 8] = 8'(8'h10 + i);
      for (int i = 0; i < 8; i++) set_tx(i, 2);
      host_rx_ready = 1'b1;
      host_tx_data = '0; host_tx_chan = '0; host_tx_valid = 1'b0;
      host_clr_chan = '0; host_clr_valid = 1'b0;
      test_reset();
      test_err_summary();
      test_write();
      test_priority_pick();
      test_round_robin();
      test_full_tx();
      test_backpressure_reset();
      test_clear();
      test_enable();
      test_alternate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
